// File: rtl/line_buffer_win.sv
// Single-line pixel buffer returning a registered WIN_W-tap horizontal window per read.
// Optional LB_EDGE_CLAMP_EN: taps past the line end replicate the last pixel instead of wrapping.
module line_buffer_win #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_LEN = 512,
  parameter int unsigned WIN_W    = 3,
  localparam int unsigned CNT_W   = $clog2(LINE_LEN + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_data_valid,
  output logic                      o_wr_ready,
  input  logic                      i_rd_data,
  output logic [WIN_W*DATA_W-1:0]   o_data,
  output logic                      o_data_valid,
  output logic                      o_line_done,
  output logic [CNT_W-1:0]          o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_overflow
);

  localparam int unsigned PTR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned LAST  = LINE_LEN - 1;

  logic [DATA_W-1:0]       mem [LINE_LEN];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count_nxt;
  logic [WIN_W*DATA_W-1:0] window_c;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    rd_at_last;

  // Reset blocks same-cycle traffic so the memory is not written either.
  assign wr_fire    = i_data_valid & ~o_full & ~i_rst;
  assign rd_fire    = i_rd_data & ~o_empty & ~i_rst;
  assign rd_at_last = (rd_ptr == PTR_W'(LAST));

  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Tap index is rd_ptr+k folded back into the line by a single compare/subtract.
  always_comb begin
    logic [SUM_W-1:0] raw;
    logic [PTR_W-1:0] idx;
    window_c = '0;
    raw      = '0;
    idx      = '0;
    for (int k = 0; k < int'(WIN_W); k++) begin
      raw = SUM_W'(rd_ptr) + SUM_W'(k);
      if (raw >= SUM_W'(LINE_LEN)) begin
`ifdef LB_EDGE_CLAMP_EN
        idx = PTR_W'(LAST);
`else
        idx = PTR_W'(raw - SUM_W'(LINE_LEN));
`endif
      end else begin
        idx = PTR_W'(raw);
      end
      window_c[(int'(WIN_W) - 1 - k) * int'(DATA_W) +: DATA_W] = mem[idx];
    end
  end

  always_comb begin
    count_nxt = o_count;
    if (wr_fire && !rd_fire) begin
      count_nxt = o_count + CNT_W'(1);
    end else if (rd_fire && !wr_fire) begin
      count_nxt = o_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_count      <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_line_done  <= 1'b0;
      o_overflow   <= 1'b0;
      o_empty      <= 1'b1;
      o_full       <= 1'b0;
      o_wr_ready   <= 1'b1;
    end else begin
      if (wr_fire) begin
        wr_ptr <= (wr_ptr == PTR_W'(LAST)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_at_last ? '0 : rd_ptr + PTR_W'(1);
        o_data <= window_c;
      end
      o_data_valid <= rd_fire;
      o_line_done  <= rd_fire & rd_at_last;
      if (i_data_valid && o_full) begin
        o_overflow <= 1'b1;
      end
      // Flags come from the next count so they line up with o_count.
      o_count    <= count_nxt;
      o_full     <= (count_nxt == CNT_W'(LINE_LEN));
      o_empty    <= (count_nxt == '0);
      o_wr_ready <= (count_nxt != CNT_W'(LINE_LEN));
    end
  end

endmodule

// File: tb/tb_line_buffer_win.sv
// Self-checking bench for line_buffer_win: directed vector table, LINE_LEN=5 streaming and
// randomized traffic against a modulo-arithmetic circular-buffer model.
module tb_line_buffer_win;

  localparam int L6 = 6;
  localparam int L5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // LINE_LEN=6 instance
  logic        r6 = 1'b1, dv6 = 1'b0, rd6 = 1'b0;
  logic [7:0]  d6 = '0;
  logic        rdy6, v6, ld6, full6, empty6, ovf6;
  logic [23:0] o6;
  logic [2:0]  c6;

  line_buffer_win #(.DATA_W(8), .LINE_LEN(L6), .WIN_W(3)) dut6 (
    .i_clk(clk), .i_rst(r6), .i_data(d6), .i_data_valid(dv6), .o_wr_ready(rdy6),
    .i_rd_data(rd6), .o_data(o6), .o_data_valid(v6), .o_line_done(ld6),
    .o_count(c6), .o_full(full6), .o_empty(empty6), .o_overflow(ovf6));

  // LINE_LEN=5 instance
  logic        r5 = 1'b1, dv5 = 1'b0, rd5 = 1'b0;
  logic [7:0]  d5 = '0;
  logic        rdy5, v5, ld5, full5, empty5, ovf5;
  logic [23:0] o5;
  logic [2:0]  c5;

  line_buffer_win #(.DATA_W(8), .LINE_LEN(L5), .WIN_W(3)) dut5 (
    .i_clk(clk), .i_rst(r5), .i_data(d5), .i_data_valid(dv5), .o_wr_ready(rdy5),
    .i_rd_data(rd5), .o_data(o5), .o_data_valid(v5), .o_line_done(ld5),
    .o_count(c5), .o_full(full5), .o_empty(empty5), .o_overflow(ovf5));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        dv;
    logic [7:0]  din;
    logic        rd;
    int          cnt;
    logic        valid;
    logic [23:0] data;
    logic        ld;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic dv, input logic [7:0] din, input logic rd,
                     input int cnt, input logic valid, input logic [23:0] data,
                     input logic ld, input logic ovf);
    vec_t v;
    v.rst = rst; v.dv = dv; v.din = din; v.rd = rd; v.cnt = cnt;
    v.valid = valid; v.data = data; v.ld = ld; v.ovf = ovf;
    vq.push_back(v);
  endtask

  task automatic check6(input string tag, input int cnt, input logic valid,
                        input logic [23:0] data, input logic ld, input logic ovf);
    chk({tag, ".count"}, 32'(c6), 32'(cnt));
    chk({tag, ".valid"}, 32'(v6), 32'(valid));
    chk({tag, ".data"}, 32'(o6), 32'(data));
    chk({tag, ".line_done"}, 32'(ld6), 32'(ld));
    chk({tag, ".overflow"}, 32'(ovf6), 32'(ovf));
    chk({tag, ".full"}, 32'(full6), 32'(cnt == L6));
    chk({tag, ".empty"}, 32'(empty6), 32'(cnt == 0));
    chk({tag, ".wr_ready"}, 32'(rdy6), 32'(cnt != L6));
  endtask

  // Reference model: circular line of L6 pixels using modulo indexing.
  logic [7:0]  m_mem [L6];
  int          m_wr, m_rd, m_cnt;
  logic        m_ovf, m_valid, m_ld;
  logic [23:0] m_data;

  task automatic model_step(input logic rst, input logic dv, input logic [7:0] din, input logic rd);
    logic wf, rf;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_ovf = 0; m_valid = 0; m_ld = 0; m_data = '0;
      return;
    end
    wf = dv && (m_cnt < L6);
    rf = rd && (m_cnt > 0);
    if (dv && m_cnt == L6) m_ovf = 1'b1;
    m_valid = rf;
    m_ld    = rf && (m_rd == L6 - 1);
    if (rf) begin
      for (int k = 0; k < 3; k++) begin
`ifdef LB_EDGE_CLAMP_EN
        m_data = {m_data[15:0], (m_rd + k >= L6) ? m_mem[L6 - 1] : m_mem[m_rd + k]};
`else
        m_data = {m_data[15:0], m_mem[(m_rd + k) % L6]};
`endif
      end
      m_rd = (m_rd + 1) % L6;
    end
    if (wf) begin
      m_mem[m_wr] = din;
      m_wr = (m_wr + 1) % L6;
    end
    m_cnt = m_cnt + int'(wf) - int'(rf);
  endtask

  task automatic rand_cycle(input logic rst, input logic dv, input logic [7:0] din, input logic rd);
    r6 = rst; dv6 = dv; d6 = din; rd6 = rd;
    model_step(rst, dv, din, rd);
    @(posedge clk); #1;
    check6("rand", m_cnt, m_valid, m_data, m_ld, m_ovf);
  endtask

  logic [23:0] exp_r4, exp_r5;

  initial begin
`ifdef LB_EDGE_CLAMP_EN
    exp_r4 = 24'h141515; exp_r5 = 24'h151515;
`else
    exp_r4 = 24'h141510; exp_r5 = 24'h151011;
`endif
    // rst dv din rd | cnt valid data ld ovf
    add(1, 0, 8'h00, 0, 0, 0, 24'h000000, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 8'(8'h10 + i), 0, i + 1, 0, 24'h000000, 0, 0);
    add(0, 1, 8'hAA, 0, 6, 0, 24'h000000, 0, 1);
    add(0, 0, 8'h00, 1, 5, 1, 24'h101112, 0, 1);
    add(0, 0, 8'h00, 1, 4, 1, 24'h111213, 0, 1);
    add(0, 0, 8'h00, 1, 3, 1, 24'h121314, 0, 1);
    add(0, 0, 8'h00, 1, 2, 1, 24'h131415, 0, 1);
    add(0, 0, 8'h00, 1, 1, 1, exp_r4,     0, 1);
    add(0, 0, 8'h00, 1, 0, 1, exp_r5,     1, 1);
    add(0, 0, 8'h00, 1, 0, 0, exp_r5,     0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 24'h000000, 0, 0);
    add(0, 1, 8'h20, 1, 1, 0, 24'h000000, 0, 0);
    add(0, 1, 8'h21, 0, 2, 0, 24'h000000, 0, 0);
    add(0, 1, 8'h22, 0, 3, 0, 24'h000000, 0, 0);
    add(0, 1, 8'h23, 1, 3, 1, 24'h202122, 0, 0);
    add(0, 0, 8'h00, 1, 2, 1, 24'h212223, 0, 0);
    add(0, 1, 8'h24, 0, 3, 1 ^ 1, 24'h212223, 0, 0);
    add(0, 0, 8'h00, 1, 2, 1, 24'h222324, 0, 0);
    add(1, 1, 8'h99, 1, 0, 0, 24'h000000, 0, 0);
    add(0, 1, 8'h30, 0, 1, 0, 24'h000000, 0, 0);
    add(0, 1, 8'h31, 0, 2, 0, 24'h000000, 0, 0);
    add(0, 0, 8'h00, 1, 1, 1, 24'h303122, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      r6 = vq[i].rst; dv6 = vq[i].dv; d6 = vq[i].din; rd6 = vq[i].rd;
      @(posedge clk); #1;
      check6($sformatf("vec%0d", i), vq[i].cnt, vq[i].valid, vq[i].data, vq[i].ld, vq[i].ovf);
    end

    // LINE_LEN=5 streaming: one pixel primed, then read+write each cycle.
    r5 = 1'b1;
    @(posedge clk); #1;
    r5 = 1'b0; dv5 = 1'b1; d5 = 8'h40; rd5 = 1'b0;
    @(posedge clk); #1;
    chk("l5.prime_count", 32'(c5), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      dv5 = (k < 12); d5 = 8'(8'h40 + k); rd5 = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("l5.rd%0d.valid", k), 32'(v5), 32'd1);
      chk($sformatf("l5.rd%0d.tap0", k), 32'(o5[23:16]), 32'(8'h40 + k - 1));
      chk($sformatf("l5.rd%0d.line_done", k), 32'(ld5), 32'((k % 5) == 0));
      chk($sformatf("l5.rd%0d.count", k), 32'(c5), (k < 12) ? 32'd1 : 32'd0);
    end
    dv5 = 1'b0; rd5 = 1'b0;

    // Randomized traffic: reset, fill and drain so every model location is defined.
    rand_cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < L6; i++) rand_cycle(0, 1, 8'($urandom), 0);
    for (int i = 0; i < L6; i++) rand_cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 400; i++) begin
      rand_cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
                 8'($urandom), ($urandom_range(0, 99) < 50));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
